// File: rtl/gerenciador_fronteira_if.sv
// ============================================================================
// Module  : gerenciador_fronteira_if
// Purpose : Command/selection bundle of the frontier manager. The "master"
//           side issues insert/relax/pop commands and observes the selected
//           node; the "slave" side is the frontier manager itself.
// Signals : atualizar_in, endereco_in, distancia_in, anterior_in,
//           heuristica_in, modo_astar_in, remover_in      (master -> slave)
//           gf_pronto_out, gf_valido_out, gf_endereco_out, gf_anterior_out,
//           gf_distancia_out, gf_criterio_out, gf_tem_ativo_out,
//           gf_cheio_out, gf_descartado_out, gf_ocupado_out,
//           gf_contagem_out                               (slave -> master)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface gerenciador_fronteira_if #(
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4,
  parameter int CRITERIO_WIDTH  = DISTANCIA_WIDTH + 1,
  parameter int CONT_WIDTH      = 4
);
  logic                       atualizar_in;
  logic [ADDR_WIDTH-1:0]      endereco_in;
  logic [DISTANCIA_WIDTH-1:0] distancia_in;
  logic [ADDR_WIDTH-1:0]      anterior_in;
  logic [CUSTO_WIDTH-1:0]     heuristica_in;
  logic                       modo_astar_in;
  logic                       remover_in;

  logic                       gf_pronto_out;
  logic                       gf_valido_out;
  logic [ADDR_WIDTH-1:0]      gf_endereco_out;
  logic [ADDR_WIDTH-1:0]      gf_anterior_out;
  logic [DISTANCIA_WIDTH-1:0] gf_distancia_out;
  logic [CRITERIO_WIDTH-1:0]  gf_criterio_out;
  logic                       gf_tem_ativo_out;
  logic                       gf_cheio_out;
  logic                       gf_descartado_out;
  logic                       gf_ocupado_out;
  logic [CONT_WIDTH-1:0]      gf_contagem_out;

  modport master (
    output atualizar_in, endereco_in, distancia_in, anterior_in,
           heuristica_in, modo_astar_in, remover_in,
    input  gf_pronto_out, gf_valido_out, gf_endereco_out, gf_anterior_out,
           gf_distancia_out, gf_criterio_out, gf_tem_ativo_out,
           gf_cheio_out, gf_descartado_out, gf_ocupado_out, gf_contagem_out
  );

  modport slave (
    input  atualizar_in, endereco_in, distancia_in, anterior_in,
           heuristica_in, modo_astar_in, remover_in,
    output gf_pronto_out, gf_valido_out, gf_endereco_out, gf_anterior_out,
           gf_distancia_out, gf_criterio_out, gf_tem_ativo_out,
           gf_cheio_out, gf_descartado_out, gf_ocupado_out, gf_contagem_out
  );
endinterface

`default_nettype wire

// File: rtl/gerenciador_fronteira.sv
// ============================================================================
// Module  : gerenciador_fronteira
// Purpose : Frontier (open-set) manager for a Dijkstra / A* search engine.
//           Holds NUM_NA active-node slots, handles insert/relax commands,
//           and after every change scans the slots one per cycle to find the
//           node with the minimum criterion (distance, or distance+heuristic
//           saturated). The selection can then be popped.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - gerenciador_fronteira_if.slave (commands in, selection,
//                    occupancy and status out)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gerenciador_fronteira #(
  parameter int NUM_NA          = 8,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4,
  parameter int CRITERIO_WIDTH  = DISTANCIA_WIDTH + 1,
  parameter int CONT_WIDTH      = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  gerenciador_fronteira_if.slave bus
);

  localparam int IDX_WIDTH  = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
  localparam int SCAN_WIDTH = $clog2(NUM_NA + 1);
  // Wide enough to hold both the raw sum and the saturation limit.
  localparam int SOMA_WIDTH = DISTANCIA_WIDTH + CUSTO_WIDTH + CRITERIO_WIDTH;
  localparam logic [CRITERIO_WIDTH-1:0] CRIT_MAX = '1;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    PRONTO = 2'd2
  } estado_t;

  // Slot storage
  logic [NUM_NA-1:0]          valido_q;
  logic [ADDR_WIDTH-1:0]      endereco_q   [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0] distancia_q  [NUM_NA];
  logic [ADDR_WIDTH-1:0]      anterior_q   [NUM_NA];
  logic [CUSTO_WIDTH-1:0]     heuristica_q [NUM_NA];

  // Scan state
  estado_t                    estado_q;
  logic [SCAN_WIDTH-1:0]      indice_q;
  logic                       melhor_valido_q;
  logic [IDX_WIDTH-1:0]       melhor_idx_q;
  logic [CRITERIO_WIDTH-1:0]  melhor_crit_q;

  // Registered outputs
  logic                       pronto_q;
  logic                       ocupado_q;
  logic                       sel_valido_q;
  logic [IDX_WIDTH-1:0]       sel_idx_q;
  logic [ADDR_WIDTH-1:0]      sel_endereco_q;
  logic [ADDR_WIDTH-1:0]      sel_anterior_q;
  logic [DISTANCIA_WIDTH-1:0] sel_distancia_q;
  logic [CRITERIO_WIDTH-1:0]  sel_criterio_q;
  logic [CONT_WIDTH-1:0]      contagem_q;
  logic [CONT_WIDTH-1:0]      contagem_d;
  logic                       tem_ativo_q;
  logic                       cheio_q;
  logic                       descartado_q;

  // Command decode
  logic                       casa;
  logic [IDX_WIDTH-1:0]       casa_idx;
  logic                       livre;
  logic [IDX_WIDTH-1:0]       livre_idx;
  logic                       insere;
  logic                       remove;
  logic                       em_faixa;
  logic [IDX_WIDTH-1:0]       slot_scan;
  logic [CRITERIO_WIDTH-1:0]  crit_scan;

  function automatic logic [CRITERIO_WIDTH-1:0] calc_criterio(
    input logic [DISTANCIA_WIDTH-1:0] d,
    input logic [CUSTO_WIDTH-1:0]     h,
    input logic                       astar
  );
    logic [SOMA_WIDTH-1:0] soma;
    soma = SOMA_WIDTH'(d) + SOMA_WIDTH'(h);
    if (!astar)
      return CRITERIO_WIDTH'(d);
    else if (soma > SOMA_WIDTH'(CRIT_MAX))
      return CRIT_MAX;
    else
      return soma[CRITERIO_WIDTH-1:0];
  endfunction

  always_comb begin
    casa      = 1'b0;
    casa_idx  = '0;
    livre     = 1'b0;
    livre_idx = '0;
    // Walk downwards so the last hit is the lowest index.
    for (int i = NUM_NA - 1; i >= 0; i--) begin
      if (valido_q[i] && (endereco_q[i] == bus.endereco_in)) begin
        casa     = 1'b1;
        casa_idx = IDX_WIDTH'(i);
      end
      if (!valido_q[i]) begin
        livre     = 1'b1;
        livre_idx = IDX_WIDTH'(i);
      end
    end
  end

  assign insere    = bus.atualizar_in && !casa && livre;
  // An insert in the same cycle wins over a pop.
  assign remove    = bus.remover_in && !bus.atualizar_in && pronto_q && sel_valido_q;
  assign em_faixa  = (indice_q < SCAN_WIDTH'(NUM_NA));
  assign slot_scan = indice_q[IDX_WIDTH-1:0];
  assign crit_scan = calc_criterio(distancia_q[slot_scan], heuristica_q[slot_scan],
                                   bus.modo_astar_in);

  always_comb begin
    contagem_d = contagem_q;
    if (insere)
      contagem_d = contagem_q + 1'b1;
    else if (remove)
      contagem_d = contagem_q - 1'b1;
  end

  // Slot payload: only meaningful while the matching valido bit is set,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (bus.atualizar_in) begin
      if (casa) begin
        if (bus.distancia_in < distancia_q[casa_idx]) begin
          distancia_q[casa_idx]  <= bus.distancia_in;
          anterior_q[casa_idx]   <= bus.anterior_in;
          heuristica_q[casa_idx] <= bus.heuristica_in;
        end
      end else if (livre) begin
        endereco_q[livre_idx]   <= bus.endereco_in;
        distancia_q[livre_idx]  <= bus.distancia_in;
        anterior_q[livre_idx]   <= bus.anterior_in;
        heuristica_q[livre_idx] <= bus.heuristica_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q        <= OCIOSO;
      valido_q        <= '0;
      indice_q        <= '0;
      melhor_valido_q <= 1'b0;
      melhor_idx_q    <= '0;
      melhor_crit_q   <= '0;
      pronto_q        <= 1'b0;
      ocupado_q       <= 1'b0;
      sel_valido_q    <= 1'b0;
      sel_idx_q       <= '0;
      sel_endereco_q  <= '0;
      sel_anterior_q  <= '0;
      sel_distancia_q <= '0;
      sel_criterio_q  <= '0;
      contagem_q      <= '0;
      tem_ativo_q     <= 1'b0;
      cheio_q         <= 1'b0;
      descartado_q    <= 1'b0;
    end else begin
      descartado_q <= 1'b0;
      contagem_q   <= contagem_d;
      tem_ativo_q  <= (contagem_d != '0);
      cheio_q      <= (contagem_d == CONT_WIDTH'(NUM_NA));

      if (bus.atualizar_in || remove) begin
        // Any change to the set invalidates the current selection.
        estado_q        <= BUSCA;
        ocupado_q       <= 1'b1;
        pronto_q        <= 1'b0;
        indice_q        <= '0;
        melhor_valido_q <= 1'b0;
        if (bus.atualizar_in) begin
          if (insere)
            valido_q[livre_idx] <= 1'b1;
          else if (!casa)
            descartado_q <= 1'b1;
        end else begin
          valido_q[sel_idx_q] <= 1'b0;
        end
      end else begin
        case (estado_q)
          BUSCA: begin
            if (em_faixa) begin
              if (valido_q[slot_scan] &&
                  (!melhor_valido_q || (crit_scan < melhor_crit_q))) begin
                melhor_valido_q <= 1'b1;
                melhor_idx_q    <= slot_scan;
                melhor_crit_q   <= crit_scan;
              end
              indice_q <= indice_q + 1'b1;
            end else begin
              // Extra cycle after the last slot registers the result.
              estado_q     <= PRONTO;
              ocupado_q    <= 1'b0;
              pronto_q     <= 1'b1;
              sel_valido_q <= melhor_valido_q;
              sel_idx_q    <= melhor_idx_q;
              if (melhor_valido_q) begin
                sel_endereco_q  <= endereco_q[melhor_idx_q];
                sel_anterior_q  <= anterior_q[melhor_idx_q];
                sel_distancia_q <= distancia_q[melhor_idx_q];
                sel_criterio_q  <= melhor_crit_q;
              end else begin
                sel_endereco_q  <= '0;
                sel_anterior_q  <= '0;
                sel_distancia_q <= '0;
                sel_criterio_q  <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.gf_pronto_out     = pronto_q;
  assign bus.gf_ocupado_out    = ocupado_q;
  assign bus.gf_valido_out     = sel_valido_q;
  assign bus.gf_endereco_out   = sel_endereco_q;
  assign bus.gf_anterior_out   = sel_anterior_q;
  assign bus.gf_distancia_out  = sel_distancia_q;
  assign bus.gf_criterio_out   = sel_criterio_q;
  assign bus.gf_contagem_out   = contagem_q;
  assign bus.gf_tem_ativo_out  = tem_ativo_q;
  assign bus.gf_cheio_out      = cheio_q;
  assign bus.gf_descartado_out = descartado_q;

endmodule

`default_nettype wire

// File: tb/tb_gerenciador_fronteira.sv
// ============================================================================
// Module  : tb_gerenciador_fronteira
// Purpose : Self-checking bench for gerenciador_fronteira (NUM_NA=4):
//           directed table of insert/relax/drop vectors, hand sequences for
//           A*, tie/pop, empty set and reset during a scan, then randomized
//           commands against a behavioural model of the frontier set.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gerenciador_fronteira;

  localparam int NUM_NA = 4;
  localparam int AW     = 5;
  localparam int DW     = 5;
  localparam int HW     = 4;
  localparam int CW     = DW + 1;
  localparam int NW     = 4;
  localparam int LAT    = NUM_NA + 1;
  localparam int CMAX   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gerenciador_fronteira_if #(
    .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(HW),
    .CRITERIO_WIDTH(CW), .CONT_WIDTH(NW)
  ) bus ();

  gerenciador_fronteira #(
    .NUM_NA(NUM_NA), .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW),
    .CUSTO_WIDTH(HW), .CRITERIO_WIDTH(CW), .CONT_WIDTH(NW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    total++;
    if (atual !== esperado) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // ---------------- behavioural model of the frontier set ----------------
  bit m_val  [NUM_NA];
  int m_addr [NUM_NA];
  int m_dist [NUM_NA];
  int m_ant  [NUM_NA];
  int m_heur [NUM_NA];
  bit m_ready;
  bit m_astar;

  function automatic int crit_of(int d, int h, bit a);
    if (!a) return d;
    return (d + h > CMAX) ? CMAX : d + h;
  endfunction

  function automatic int model_sel();
    int best = -1;
    for (int i = 0; i < NUM_NA; i++)
      if (m_val[i] && (best < 0 ||
          crit_of(m_dist[i], m_heur[i], m_astar) < crit_of(m_dist[best], m_heur[best], m_astar)))
        best = i;
    return best;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NUM_NA; i++) n += int'(m_val[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_NA; i++) m_val[i] = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic model_cmd(input bit upd, input int a, input int d, input int an, input int h,
                           input bit rem, output bit drop, output bit started);
    int hit = -1;
    int fr  = -1;
    int s;
    drop = 1'b0;
    started = 1'b0;
    if (upd) begin
      started = 1'b1;
      for (int i = NUM_NA - 1; i >= 0; i--) begin
        if (m_val[i] && m_addr[i] == a) hit = i;
        if (!m_val[i]) fr = i;
      end
      if (hit >= 0) begin
        if (d < m_dist[hit]) begin
          m_dist[hit] = d; m_ant[hit] = an; m_heur[hit] = h;
        end
      end else if (fr >= 0) begin
        m_val[fr] = 1'b1; m_addr[fr] = a; m_dist[fr] = d; m_ant[fr] = an; m_heur[fr] = h;
      end else begin
        drop = 1'b1;
      end
    end else if (rem && m_ready) begin
      s = model_sel();
      if (s >= 0) begin
        m_val[s] = 1'b0;
        started = 1'b1;
      end
    end
    if (started) m_ready = 1'b0;
  endtask

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic cmd(input bit upd, input int a, input int d, input int an, input int h,
                     input bit rem, output bit drop, output bit started);
    bus.atualizar_in  = upd;
    bus.endereco_in   = a[AW-1:0];
    bus.distancia_in  = d[DW-1:0];
    bus.anterior_in   = an[AW-1:0];
    bus.heuristica_in = h[HW-1:0];
    bus.remover_in    = rem;
    model_cmd(upd, a, d, an, h, rem, drop, started);
    @(negedge clk);
    bus.atualizar_in = 1'b0;
    bus.remover_in   = 1'b0;
  endtask

  task automatic wait_pronto(input int esperado, input string tag);
    int ciclos = 0;
    while (!bus.gf_pronto_out && ciclos < 40) begin
      @(negedge clk);
      ciclos++;
    end
    chk({tag, "_latencia"}, 32'(ciclos), 32'(esperado));
    m_ready = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pronto"},     32'(bus.gf_pronto_out), 0);
    chk({tag, "_valido"},     32'(bus.gf_valido_out), 0);
    chk({tag, "_endereco"},   32'(bus.gf_endereco_out), 0);
    chk({tag, "_anterior"},   32'(bus.gf_anterior_out), 0);
    chk({tag, "_distancia"},  32'(bus.gf_distancia_out), 0);
    chk({tag, "_criterio"},   32'(bus.gf_criterio_out), 0);
    chk({tag, "_tem_ativo"},  32'(bus.gf_tem_ativo_out), 0);
    chk({tag, "_cheio"},      32'(bus.gf_cheio_out), 0);
    chk({tag, "_descartado"}, 32'(bus.gf_descartado_out), 0);
    chk({tag, "_ocupado"},    32'(bus.gf_ocupado_out), 0);
    chk({tag, "_contagem"},   32'(bus.gf_contagem_out), 0);
  endtask

  task automatic check_model(input string tag);
    int s = model_sel();
    int n = model_count();
    chk({tag, "_pronto"},  32'(bus.gf_pronto_out), 1);
    chk({tag, "_ocupado"}, 32'(bus.gf_ocupado_out), 0);
    chk({tag, "_valido"},  32'(bus.gf_valido_out), (s >= 0) ? 1 : 0);
    chk({tag, "_endereco"},  32'(bus.gf_endereco_out),  (s >= 0) ? m_addr[s] : 0);
    chk({tag, "_distancia"}, 32'(bus.gf_distancia_out), (s >= 0) ? m_dist[s] : 0);
    chk({tag, "_anterior"},  32'(bus.gf_anterior_out),  (s >= 0) ? m_ant[s] : 0);
    chk({tag, "_criterio"},  32'(bus.gf_criterio_out),
        (s >= 0) ? crit_of(m_dist[s], m_heur[s], m_astar) : 0);
    chk({tag, "_contagem"},  32'(bus.gf_contagem_out), n);
    chk({tag, "_tem_ativo"}, 32'(bus.gf_tem_ativo_out), (n > 0) ? 1 : 0);
    chk({tag, "_cheio"},     32'(bus.gf_cheio_out), (n == NUM_NA) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.atualizar_in = 1'b0;
    bus.remover_in   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int a, d, an, h;
    int e_addr, e_dist, e_ant, e_cnt;
    bit e_cheio, e_desc;
  } vec_t;

  vec_t tabela[8];

  initial begin
    bit drop, started, seen;
    int k;

    tabela[0] = '{a:3, d:7, an:2, h:0, e_addr:3, e_dist:7, e_ant:2, e_cnt:1, e_cheio:0, e_desc:0};
    tabela[1] = '{a:3, d:9, an:6, h:0, e_addr:3, e_dist:7, e_ant:2, e_cnt:1, e_cheio:0, e_desc:0};
    tabela[2] = '{a:3, d:4, an:5, h:0, e_addr:3, e_dist:4, e_ant:5, e_cnt:1, e_cheio:0, e_desc:0};
    tabela[3] = '{a:1, d:2, an:0, h:0, e_addr:1, e_dist:2, e_ant:0, e_cnt:2, e_cheio:0, e_desc:0};
    tabela[4] = '{a:6, d:9, an:1, h:0, e_addr:1, e_dist:2, e_ant:0, e_cnt:3, e_cheio:0, e_desc:0};
    tabela[5] = '{a:7, d:3, an:4, h:0, e_addr:1, e_dist:2, e_ant:0, e_cnt:4, e_cheio:1, e_desc:0};
    tabela[6] = '{a:9, d:0, an:7, h:0, e_addr:1, e_dist:2, e_ant:0, e_cnt:4, e_cheio:1, e_desc:1};
    tabela[7] = '{a:7, d:1, an:3, h:0, e_addr:7, e_dist:1, e_ant:3, e_cnt:4, e_cheio:1, e_desc:0};

    bus.atualizar_in  = 1'b0;
    bus.remover_in    = 1'b0;
    bus.endereco_in   = '0;
    bus.distancia_in  = '0;
    bus.anterior_in   = '0;
    bus.heuristica_in = '0;
    bus.modo_astar_in = 1'b0;
    m_astar = 1'b0;
    model_clear();

    // Outputs held at zero while in reset
    @(negedge clk);
    chk_zero("reset");
    do_reset();

    // Directed insert / relax / drop table (Dijkstra)
    for (int i = 0; i < 8; i++) begin
      cmd(1'b1, tabela[i].a, tabela[i].d, tabela[i].an, tabela[i].h, 1'b0, drop, started);
      chk($sformatf("tab%0d_descartado", i), 32'(bus.gf_descartado_out), 32'(tabela[i].e_desc));
      wait_pronto(LAT, $sformatf("tab%0d", i));
      chk($sformatf("tab%0d_valido", i),    32'(bus.gf_valido_out), 1);
      chk($sformatf("tab%0d_endereco", i),  32'(bus.gf_endereco_out), 32'(tabela[i].e_addr));
      chk($sformatf("tab%0d_distancia", i), 32'(bus.gf_distancia_out), 32'(tabela[i].e_dist));
      chk($sformatf("tab%0d_anterior", i),  32'(bus.gf_anterior_out), 32'(tabela[i].e_ant));
      chk($sformatf("tab%0d_criterio", i),  32'(bus.gf_criterio_out), 32'(tabela[i].e_dist));
      chk($sformatf("tab%0d_contagem", i),  32'(bus.gf_contagem_out), 32'(tabela[i].e_cnt));
      chk($sformatf("tab%0d_cheio", i),     32'(bus.gf_cheio_out), 32'(tabela[i].e_cheio));
    end
    // The drop pulse lasts one cycle only
    cmd(1'b1, 12, 0, 0, 0, 1'b0, drop, started);
    chk("drop_pulso", 32'(bus.gf_descartado_out), 1);
    @(negedge clk);
    chk("drop_fim_pulso", 32'(bus.gf_descartado_out), 0);
    wait_pronto(LAT - 1, "drop");

    // A* criterion
    do_reset();
    bus.modo_astar_in = 1'b1;
    m_astar = 1'b1;
    cmd(1'b1, 1, 31, 0, 15, 1'b0, drop, started);
    wait_pronto(LAT, "astar_a");
    chk("astar_crit46", 32'(bus.gf_criterio_out), 46);
    cmd(1'b1, 2, 10, 4, 0, 1'b0, drop, started);
    wait_pronto(LAT, "astar_b");
    cmd(1'b1, 3, 5, 6, 9, 1'b0, drop, started);
    wait_pronto(LAT, "astar_c");
    chk("astar_endereco", 32'(bus.gf_endereco_out), 2);
    chk("astar_distancia", 32'(bus.gf_distancia_out), 10);
    chk("astar_criterio", 32'(bus.gf_criterio_out), 10);

    // Tie, pop, ignored pop while busy, pop until empty
    do_reset();
    bus.modo_astar_in = 1'b0;
    m_astar = 1'b0;
    cmd(1'b1, 4, 5, 1, 0, 1'b0, drop, started);
    cmd(1'b1, 8, 9, 1, 0, 1'b0, drop, started);
    cmd(1'b1, 2, 5, 1, 0, 1'b0, drop, started);
    wait_pronto(LAT, "empate");
    chk("empate_endereco", 32'(bus.gf_endereco_out), 4);
    cmd(1'b0, 0, 0, 0, 0, 1'b1, drop, started);
    wait_pronto(LAT, "pop1");
    chk("pop1_endereco", 32'(bus.gf_endereco_out), 2);
    chk("pop1_contagem", 32'(bus.gf_contagem_out), 2);
    cmd(1'b0, 0, 0, 0, 0, 1'b1, drop, started);
    chk("pop2_ocupado", 32'(bus.gf_ocupado_out), 1);
    cmd(1'b0, 0, 0, 0, 0, 1'b1, drop, started);
    wait_pronto(LAT - 1, "pop_ocupado");
    chk("pop_ocupado_endereco", 32'(bus.gf_endereco_out), 8);
    chk("pop_ocupado_contagem", 32'(bus.gf_contagem_out), 1);
    cmd(1'b0, 0, 0, 0, 0, 1'b1, drop, started);
    wait_pronto(LAT, "vazio");
    check_model("vazio");

    // Reset in the middle of a scan
    cmd(1'b1, 5, 3, 1, 0, 1'b0, drop, started);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("reset_busca");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.gf_pronto_out || bus.gf_ocupado_out || bus.gf_descartado_out) seen = 1'b1;
    end
    chk("pos_reset_pulso", 32'(seen), 0);

    // Randomized commands against the model
    do_reset();
    for (int it = 0; it < 200; it++) begin
      if (it == 0 || $urandom_range(0, 9) < 7) begin
        m_astar = 1'($urandom_range(0, 1));
        bus.modo_astar_in = m_astar;
        cmd(1'b1, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 15), ($urandom_range(0, 4) == 0), drop, started);
        chk("rnd_descartado", 32'(bus.gf_descartado_out), 32'(drop));
        if ($urandom_range(0, 3) == 0) begin
          k = $urandom_range(1, 3);
          repeat (k) @(negedge clk);
          cmd(1'b1, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 15), 1'b0, drop, started);
          chk("rnd_descartado2", 32'(bus.gf_descartado_out), 32'(drop));
        end
        wait_pronto(LAT, "rnd_ins");
      end else begin
        cmd(1'b0, 0, 0, 0, 0, 1'b1, drop, started);
        wait_pronto(started ? LAT : 0, "rnd_pop");
      end
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gerenciador_fronteira.md
GERENCIADOR_FRONTEIRA -- requirements
Module: gerenciador_fronteira

Interface
REQ-001 SHALL have parameter NUM_NA, default 8, number of active-node slots (>=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, node address width.
REQ-003 SHALL have parameter DISTANCIA_WIDTH, default 5, accumulated-distance width.
REQ-004 SHALL have parameter CUSTO_WIDTH, default 4, heuristic width.
REQ-005 SHALL have parameter CRITERIO_WIDTH, default DISTANCIA_WIDTH+1, criterion width.
REQ-006 SHALL have parameter CONT_WIDTH, default 4, occupancy-count width (>= ceil(log2(NUM_NA+1))).
REQ-007 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- atualizar_in  in  1  insert/relax command strobe.
- endereco_in  in  ADDR_WIDTH  node address.
- distancia_in  in  DISTANCIA_WIDTH  candidate distance.
- anterior_in  in  ADDR_WIDTH  candidate predecessor.
- heuristica_in  in  CUSTO_WIDTH  node heuristic.
- modo_astar_in  in  1  1 = A* criterion, 0 = Dijkstra criterion; static while gf_ocupado_out is high.
- remover_in  in  1  pop the currently selected node.
- gf_pronto_out  out  1  selection valid and stable.
- gf_valido_out  out  1  selection holds a node (set not empty).
- gf_endereco_out, gf_anterior_out  out  ADDR_WIDTH  selected node fields.
- gf_distancia_out  out  DISTANCIA_WIDTH  selected node distance.
- gf_criterio_out  out  CRITERIO_WIDTH  selected criterion.
- gf_tem_ativo_out  out  1  at least one slot valid.
- gf_cheio_out  out  1  all slots valid.
- gf_descartado_out  out  1  one-cycle pulse, insert dropped.
- gf_ocupado_out  out  1  search in progress.
- gf_contagem_out  out  CONT_WIDTH  number of valid slots.

Function
REQ-008 SHALL store per slot: valido, endereco, distancia, anterior, heuristica.
REQ-009 On atualizar_in with address matching a valid slot: SHALL overwrite distancia/anterior/heuristica only if distancia_in < stored distancia (strict); otherwise no change.
REQ-010 On atualizar_in with no match and a free slot: SHALL write the lowest-index free slot and set its valido.
REQ-011 On atualizar_in with no match and gf_cheio_out high: SHALL drop the insert and pulse gf_descartado_out the next cycle.
REQ-012 Criterion SHALL be the zero-extended distancia when modo_astar_in=0, and distancia+heuristica saturated at 2^CRITERIO_WIDTH-1 when modo_astar_in=1.
REQ-013 FSM states: OCIOSO, BUSCA, PRONTO. Reset goes to OCIOSO.
REQ-014 Any accepted atualizar_in or remover_in SHALL move the FSM to BUSCA on the next edge, from any state, restarting the scan at index 0.
REQ-015 BUSCA SHALL examine one slot per cycle, index 0..NUM_NA-1, tracking the minimum criterion over valid slots; ties go to the lowest index (strict < compare).
REQ-016 After the last slot, the FSM SHALL enter PRONTO; gf_pronto_out SHALL assert exactly NUM_NA+1 cycles after the command edge, if no further command arrives.
REQ-017 gf_ocupado_out SHALL be high exactly in BUSCA. gf_pronto_out SHALL be high exactly in PRONTO.
REQ-018 Selection outputs SHALL be registered and held constant during PRONTO. If no slot is valid, gf_valido_out=0 and the other selection fields are 0.
REQ-019 remover_in SHALL be honoured only when gf_pronto_out=1 and gf_valido_out=1: it clears the selected slot's valido and triggers a new search. Otherwise it SHALL be ignored.
REQ-020 Simultaneous atualizar_in and remover_in: atualizar_in SHALL take effect and remover_in SHALL be ignored that cycle.
REQ-021 gf_contagem_out, gf_tem_ativo_out and gf_cheio_out SHALL reflect slot state registered at the same edge as the slot write.

Reset
REQ-022 rst_n low SHALL asynchronously clear all valido bits, force the FSM to OCIOSO, and drive every output to 0.
REQ-023 Reset asserted during BUSCA SHALL abort the search with no residual pulse after release.

Verification
REQ-024 NUM_NA=4, Dijkstra mode: insert (addr 3, dist 7), then (addr 1, dist 2) -> gf_pronto_out=1 five cycles after the second insert; selection addr 1, dist 2; gf_contagem_out=2.
REQ-025 Relax: existing addr 3 with dist 7; insert addr 3 with dist 9 -> no change. Insert addr 3 with dist 4, anterior 5 -> slot updated; gf_anterior_out=5 when addr 3 is selected.
REQ-026 A* mode, DISTANCIA_WIDTH=5: dist 31 with heuristic 15 -> criterion 46. Dist 10/heur 0 versus dist 5/heur 9 -> select dist 10 (criterion 10 < 14).
REQ-027 Fill all 4 slots, then insert a new address -> gf_descartado_out pulses 1 cycle; gf_cheio_out stays 1; gf_contagem_out stays 4.
REQ-028 Tie and pop: slots 0 and 2 with equal criterion -> slot 0 selected. remover_in in PRONTO -> slot 2 selected after 5 cycles. remover_in while gf_ocupado_out=1 -> ignored.
REQ-029 Pop until empty -> gf_valido_out=0, gf_tem_ativo_out=0, gf_pronto_out=1. Reset mid-BUSCA -> all outputs 0 immediately.
